// File: rtl/sobel_edge_if.sv
`default_nettype none
// ------------------------------------------------------------------
// sobel_edge_if : one pixel-stream beat (valid + 8-bit RGB), rev 1.0
// ------------------------------------------------------------------
interface sobel_edge_if;
  logic       valid;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  modport master (output valid, r, g, b);
  modport slave  (input  valid, r, g, b);
endinterface
`default_nettype wire

// File: rtl/sobel_edge.sv
`default_nettype none
// ------------------------------------------------------------------
// sobel_edge : streaming 3x3 Sobel |Gx|+|Gy| with RGB bypass, rev 1.0
// ------------------------------------------------------------------
module sobel_edge #(
  parameter int H_ACTIVE = 640,
  parameter int THRESH   = 0
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  input  wire logic    enable_i,
  input  wire logic    frame_en_i,
  sobel_edge_if.slave  pix_i,
  sobel_edge_if.master pix_o
);
  localparam int               COL_W      = $clog2(H_ACTIVE);
  localparam logic [COL_W-1:0] c_col_last = COL_W'(H_ACTIVE - 1);

  logic [COL_W-1:0] col_q, col_d, w_col;
  logic [1:0]       row_q, row_d, w_row;
  logic             en_q, w_en;

  logic [7:0] lb0_q [H_ACTIVE];
  logic [7:0] lb1_q [H_ACTIVE];
  logic [7:0] win_q [3][3];
  logic [7:0] w_lb0, w_lb1;

  logic        vld1_q, en1_q, bord1_q;
  logic [23:0] rgb1_q;
  logic        vld2_q;
  logic [23:0] rgb2_q;

  // frame_en clears counters in the same cycle it arrives, so a pixel
  // accompanying it is (row 0, col 0) and is governed by the new enable.
  always_comb begin
    w_col = frame_en_i ? '0 : col_q;
    w_row = frame_en_i ? '0 : row_q;
    w_en  = frame_en_i ? enable_i : en_q;
    col_d = w_col;
    row_d = w_row;
    if (pix_i.valid) begin
      if (w_col == c_col_last) begin
        col_d = '0;
        row_d = (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
      end else begin
        col_d = w_col + COL_W'(1);
      end
    end
  end

  assign w_lb0 = lb0_q[w_col];
  assign w_lb1 = lb1_q[w_col];

  always_ff @(posedge clk) begin
    if (pix_i.valid) begin
      lb0_q[w_col] <= pix_i.g;
      lb1_q[w_col] <= w_lb0;
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
      end
      win_q[0][2] <= w_lb1;
      win_q[1][2] <= w_lb0;
      win_q[2][2] <= pix_i.g;
    end
  end

  // Unsigned differences give |Gx| and |Gy| directly without sign handling.
  logic [9:0]  w_xp, w_xn, w_yp, w_yn;
  logic [11:0] w_ax, w_ay, w_mag;
  logic [7:0]  w_edge, w_pix;

  assign w_xp = {2'b0, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b0, win_q[2][2]};
  assign w_xn = {2'b0, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b0, win_q[2][0]};
  assign w_yp = {2'b0, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b0, win_q[2][2]};
  assign w_yn = {2'b0, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b0, win_q[0][2]};
  assign w_ax = (w_xp >= w_xn) ? {2'b0, w_xp - w_xn} : {2'b0, w_xn - w_xp};
  assign w_ay = (w_yp >= w_yn) ? {2'b0, w_yp - w_yn} : {2'b0, w_yn - w_yp};
  assign w_mag = w_ax + w_ay;

  generate
    if (THRESH == 0) begin : g_raw
      assign w_edge = (w_mag > 12'd255) ? 8'hFF : w_mag[7:0];
    end else begin : g_thresh
      localparam logic [11:0] c_thresh = 12'(THRESH);
      assign w_edge = (w_mag >= c_thresh) ? 8'hFF : 8'h00;
    end
  endgenerate

  assign w_pix = bord1_q ? 8'h00 : w_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      en_q    <= 1'b0;
      vld1_q  <= 1'b0;
      en1_q   <= 1'b0;
      bord1_q <= 1'b0;
      rgb1_q  <= '0;
      vld2_q  <= 1'b0;
      rgb2_q  <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      en_q   <= w_en;
      vld1_q <= pix_i.valid;
      if (pix_i.valid) begin
        en1_q   <= w_en;
        bord1_q <= (w_row < 2'd2) || (w_col < COL_W'(2));
        rgb1_q  <= {pix_i.r, pix_i.g, pix_i.b};
      end
      vld2_q <= vld1_q;
      if (vld1_q) begin
        rgb2_q <= en1_q ? {3{w_pix}} : rgb1_q;
      end
    end
  end

  assign pix_o.valid = vld2_q;
  assign pix_o.r     = rgb2_q[23:16];
  assign pix_o.g     = rgb2_q[15:8];
  assign pix_o.b     = rgb2_q[7:0];
endmodule
`default_nettype wire

// File: tb/tb_sobel_edge.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sobel_edge : randomized bench with image-level Sobel model, rev 1.0
// ------------------------------------------------------------------
module tb_sobel_edge;
  localparam int H = 8;

  logic clk, rst_n, enable, frame_en;
  sobel_edge_if in_bus ();
  sobel_edge_if out0 ();
  sobel_edge_if out80 ();
  sobel_edge_if out81 ();

  sobel_edge #(.H_ACTIVE(H), .THRESH(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .frame_en_i(frame_en), .pix_i(in_bus), .pix_o(out0));
  sobel_edge #(.H_ACTIVE(H), .THRESH(80)) u_dut80 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .frame_en_i(frame_en), .pix_i(in_bus), .pix_o(out80));
  sobel_edge #(.H_ACTIVE(H), .THRESH(81)) u_dut81 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .frame_en_i(frame_en), .pix_i(in_bus), .pix_o(out81));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int tmg_err = 0;
  logic [1:0]  vhist = 2'b00;
  logic [71:0] exp_q[$];
  logic [71:0] cap_q[$];
  int img [0:15][0:H-1];
  int m_r = 0, m_c = 0;
  bit m_en = 0;

  // Output monitor: records valid beats and checks the 2-cycle valid trail.
  always @(negedge clk) begin
    if (!rst_n) begin
      vhist = 2'b00;
      if (out0.valid !== 1'b0 || out80.valid !== 1'b0 || out81.valid !== 1'b0) tmg_err++;
    end else begin
      if (out0.valid !== vhist[1] || out80.valid !== vhist[1] || out81.valid !== vhist[1]) tmg_err++;
      if (out0.valid === 1'b1)
        cap_q.push_back({out0.r, out0.g, out0.b, out80.r, out80.g, out80.b, out81.r, out81.g, out81.b});
      vhist = {vhist[0], in_bus.valid};
    end
  end

  function automatic int model_mag(int r, int c);
    int gx, gy;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  function automatic logic [7:0] gray_of(int kind, int c);
    case (kind)
      0:       return 8'd100;
      1:       return (c < 4) ? 8'd0 : 8'd200;
      2:       return 8'(10 * c);
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_bus.valid = 1'b0;
      frame_en     = 1'b0;
    end
  endtask

  task automatic send(input bit fe, input logic [7:0] R, input logic [7:0] G, input logic [7:0] B);
    int m, sat;
    @(posedge clk); #1;
    frame_en = fe; in_bus.valid = 1'b1;
    in_bus.r = R; in_bus.g = G; in_bus.b = B;
    if (fe) begin m_en = enable; m_r = 0; m_c = 0; end
    img[m_r][m_c] = G;
    m   = (m_r < 2 || m_c < 2) ? 0 : model_mag(m_r, m_c);
    sat = (m > 255) ? 255 : m;
    if (m_en) exp_q.push_back({{3{8'(sat)}}, {3{(m >= 80) ? 8'hFF : 8'h00}}, {3{(m >= 81) ? 8'hFF : 8'h00}}});
    else      exp_q.push_back({3{R, G, B}});
    m_c++;
    if (m_c == H) begin m_c = 0; m_r++; end
  endtask

  task automatic send_frame(input int lines, input int kind, input int maxgap, input int toggle_at);
    logic [7:0] g;
    for (int r = 0; r < lines; r++) begin
      for (int c = 0; c < H; c++) begin
        if (r * H + c == toggle_at) enable = ~enable;
        g = gray_of(kind, c);
        if (kind == 3) send(r == 0 && c == 0, 8'($urandom_range(0, 255)), g, 8'($urandom_range(0, 255)));
        else           send(r == 0 && c == 0, g, g, g);
        idle($urandom_range(0, maxgap));
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_bus.valid = 1'b1; in_bus.r = 8'(i + 1); in_bus.g = 8'(i + 2); in_bus.b = 8'(i + 3);
      @(negedge clk);
      vectors++;
      if ({out0.valid, out0.r, out0.g, out0.b} !== 25'd0) begin
        miscompares++;
        $display("FAIL reset_out got v=%b rgb=%h exp v=0 rgb=000000", out0.valid, {out0.r, out0.g, out0.b});
      end
    end
    idle(1);
    rst_n = 1'b1;
    idle(2);
    cap_q.delete(); exp_q.delete(); tmg_err = 0;
    enable = 1'b0;
    send(1'b1, 8'd10, 8'd20, 8'd30);
    @(negedge clk);
    vectors++;
    if (out0.valid !== 1'b0) begin miscompares++; $display("FAIL lat_t0 got v=%b exp v=0", out0.valid); end
    @(posedge clk); #1;
    in_bus.valid = 1'b0; frame_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (out0.valid !== 1'b0) begin miscompares++; $display("FAIL lat_t1 got v=%b exp v=0", out0.valid); end
    @(negedge clk);
    vectors++;
    if ({out0.valid, out0.r, out0.g, out0.b} !== {1'b1, 24'h0A141E}) begin
      miscompares++;
      $display("FAIL lat_t2 got v=%b rgb=%h exp v=1 rgb=0a141e", out0.valid, {out0.r, out0.g, out0.b});
    end
    idle(3);
    vectors++;
    if (cap_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL reset_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL reset_px%0d got %h exp %h", i, (i < cap_q.size()) ? cap_q[i] : 72'hx, exp_q[i]);
      end
    end
    vectors++;
    if (tmg_err !== 0) begin miscompares++; $display("FAIL reset_timing got %0d errs exp 0", tmg_err); end
  endtask

  task automatic test_flat;
    cap_q.delete(); exp_q.delete(); tmg_err = 0;
    enable = 1'b1;
    send_frame(4, 0, 0, -1);
    idle(4);
    vectors++;
    if (cap_q.size() !== 32) begin miscompares++; $display("FAIL flat_count got %0d exp 32", cap_q.size()); end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL flat_px%0d got %h exp %h", i, (i < cap_q.size()) ? cap_q[i] : 72'hx, exp_q[i]);
      end
    end
    vectors++;
    if (tmg_err !== 0) begin miscompares++; $display("FAIL flat_timing got %0d errs exp 0", tmg_err); end
  endtask

  task automatic test_vertical_edge;
    cap_q.delete(); exp_q.delete(); tmg_err = 0;
    enable = 1'b1;
    send_frame(4, 1, 0, -1);
    idle(4);
    vectors++;
    if (cap_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL vedge_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL vedge_px%0d got %h exp %h", i, (i < cap_q.size()) ? cap_q[i] : 72'hx, exp_q[i]);
      end
    end
    vectors++;
    if (tmg_err !== 0) begin miscompares++; $display("FAIL vedge_timing got %0d errs exp 0", tmg_err); end
  endtask

  task automatic test_ramp;
    cap_q.delete(); exp_q.delete(); tmg_err = 0;
    enable = 1'b1;
    send_frame(4, 2, 0, -1);
    idle(4);
    vectors++;
    if (cap_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL ramp_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL ramp_px%0d got %h exp %h", i, (i < cap_q.size()) ? cap_q[i] : 72'hx, exp_q[i]);
      end
    end
    vectors++;
    if (tmg_err !== 0) begin miscompares++; $display("FAIL ramp_timing got %0d errs exp 0", tmg_err); end
  endtask

  task automatic test_bubbles;
    cap_q.delete(); exp_q.delete(); tmg_err = 0;
    enable = 1'b1;
    send_frame(4, 2, 3, -1);
    send_frame(5, 3, 2, -1);
    idle(4);
    vectors++;
    if (cap_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL bubble_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL bubble_px%0d got %h exp %h", i, (i < cap_q.size()) ? cap_q[i] : 72'hx, exp_q[i]);
      end
    end
    vectors++;
    if (tmg_err !== 0) begin miscompares++; $display("FAIL bubble_timing got %0d errs exp 0", tmg_err); end
  endtask

  task automatic test_enable_timing;
    logic [7:0] v;
    cap_q.delete(); exp_q.delete(); tmg_err = 0;
    enable = 1'b1;
    send_frame(4, 3, 1, 12);
    send_frame(3, 3, 1, -1);
    // Mid-line reset: 12 pixels accepted, the last three still in flight.
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      v = 8'($urandom_range(0, 255));
      send(i == 0, v, v, v);
    end
    rst_n = 1'b0;
    in_bus.valid = 1'b0; frame_en = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out0.valid, out0.r, out0.g, out0.b} !== 25'd0) begin
      miscompares++;
      $display("FAIL rst_drop got v=%b rgb=%h exp v=0 rgb=000000", out0.valid, {out0.r, out0.g, out0.b});
    end
    vectors++;
    if (cap_q.size() !== exp_q.size() - 3) begin
      miscompares++; $display("FAIL en_count got %0d exp %0d", cap_q.size(), exp_q.size() - 3);
    end
    for (int i = 0; i < exp_q.size() - 3; i++) begin
      vectors++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL en_px%0d got %h exp %h", i, (i < cap_q.size()) ? cap_q[i] : 72'hx, exp_q[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_en = 1'b0;
    cap_q.delete(); exp_q.delete();
    idle(2);
    enable = 1'b1;
    send_frame(4, 3, 0, -1);
    idle(4);
    vectors++;
    if (cap_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL postrst_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL postrst_px%0d got %h exp %h", i, (i < cap_q.size()) ? cap_q[i] : 72'hx, exp_q[i]);
      end
    end
    vectors++;
    if (tmg_err !== 0) begin miscompares++; $display("FAIL en_timing got %0d errs exp 0", tmg_err); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; enable = 1'b0; frame_en = 1'b0;
    in_bus.valid = 1'b0; in_bus.r = 8'd0; in_bus.g = 8'd0; in_bus.b = 8'd0;
    test_reset;
    test_flat;
    test_vertical_edge;
    test_ramp;
    test_bubbles;
    test_enable_timing;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sobel_edge.md
# sobel_edge

Streaming 3x3 Sobel edge detector placed directly downstream of the grayscale stage in the camera video pipeline. Consumes one gray pixel per valid cycle and holds two line buffers plus a 3x3 window. Emits the saturated gradient magnitude |Gx|+|Gy| on all three colour channels. The enable is sampled only at frame boundaries, so the filter never switches mid-frame; when disabled, RGB passes through with identical latency.

## Interface
- H_ACTIVE, 640, active pixels per line (line-buffer depth, column wrap point); minimum 4.
- THRESH, 0, 0 = output raw saturated magnitude; nonzero = binary output, 255 if magnitude >= THRESH else 0.

- clk  input  1  pixel clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  requested filter enable; sampled only when frame_en=1.
- frame_en  input  1  one-cycle start-of-frame pulse; clears row/column counters.
- in_valid  input  1  in_R/G/B carry a pixel this cycle.
- in_R, in_G, in_B  input  8 each  pixel in; in_G is used as luma (upstream stage drives R=G=B).
- out_valid  output  1  out_R/G/B valid.
- out_R, out_G, out_B  output  8 each  edge magnitude (enabled) or delayed input (disabled).

## Operation
- en register: on frame_en, en <= enable. Otherwise holds. Reset clears it to 0.
- Counters: col (0..H_ACTIVE-1) advances on in_valid and wraps to 0. On wrap, row increments, saturating at 2 (only row<2 matters).
  - frame_en clears col and row.
  - frame_en together with in_valid: counters clear, and that pixel is (row 0, col 0).
- Line buffers: LB0 holds the previous line and LB1 the line before it, both indexed by col.
  - On in_valid: read LB0[col] and LB1[col], then write LB1[col] <= LB0[col] and LB0[col] <= in_G (read-before-write).
  - Buffer contents are not reset.
- Window: on in_valid, three 3-tap shift registers shift by one column; the new column is {LB1 out, LB0 out, in_G}, i.e. rows r-2, r-1, r. The window does not shift when in_valid=0.
- Pixel at (r,c) uses window rows r-2..r and cols c-2..c, centred at (r-1,c-1). The output image is therefore shifted one line down and one pixel right; this is intended.
- Gradient, with p[i][j], i=row 0..2 (oldest first), j=col 0..2 (oldest first):
  - Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20).
  - Gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02).
  - Gx and Gy are 11-bit signed (range ±1020). mag = |Gx| + |Gy| is 11-bit unsigned (max 2040) and saturates to 255.
- Border: if r<2 or c<2, magnitude is forced to 0.
- Output, enabled: out_R = out_G = out_B = (THRESH==0 ? sat(mag) : (mag>=THRESH ? 255 : 0)). The threshold compares the unsaturated mag.
- Output, disabled: out_R/G/B = in_R/G/B of the same pixel, delayed identically. Line buffers and counters keep running, so re-enabling at the next frame has correct history.

## Timing
- Two-stage pipeline: out_valid = in_valid delayed exactly 2 clocks, whether enabled or disabled and regardless of in_valid gaps.
- Stage 1 registers the window and the border flag. Stage 2 registers the arithmetic result and the mux.
- Pixel accepted at cycle t appears at cycle t+2.
- out_R/G/B hold their last value while out_valid=0.
- Reset (async assert, mid-frame included):
  - out_valid, out_R/G/B, en, col, row and pipeline valids go to 0 immediately.
  - Pixels in flight are dropped.
  - The first frame after reset passes through until a frame_en samples enable=1.
- enable changing without frame_en has no effect. en takes its new value on the clock edge where frame_en=1, and applies to the pixel accepted in that cycle.

## Test plan
- Reset: drive pixels with rst_n=0 -> out_valid=0, out_R/G/B=0. Release, then frame_en with enable=0 and pixel (10,20,30) -> out=(10,20,30) with out_valid exactly 2 cycles later.
- Flat field, H_ACTIVE=8, enable=1, 4 lines of value 100 -> every output pixel 0 (borders forced, interior gradient 0). Exactly 32 out_valid pulses.
- Vertical edge, cols 0-3=0, cols 4-7=200, 4 lines -> rows 2-3: col4=255, col5=255 (Gx=800, saturated), col 2, 3, 6, 7 = 0. Rows 0-1 all 0.
- Ramp in_G=10*col, THRESH=0 -> rows>=2, cols>=2 output 80. THRESH=80 -> 255. THRESH=81 -> 0.
- Bubbles: repeat the ramp with random in_valid gaps -> identical output sequence. out_valid still trails in_valid by 2 cycles.
- Enable timing: toggle enable to 0 mid-frame -> frame stays filtered, next frame passes through. Assert rst_n low mid-line -> out_valid drops the same cycle, and the next frame's rows 0-1 output 0 when enabled.
